// File: rtl/m68k_irq_ctrl.sv
// Vblank / MCU interrupt sequencer with autovectored IACK and an optional frame watchdog.
// Define WATCHDOG_EN to build the watchdog counter and FSM; otherwise wdog_reset is tied low.
module m68k_irq_ctrl #(
   parameter logic [2:0] VBL_IPL     = 3'd1,
   parameter logic [2:0] MCU_IPL     = 3'd2,
   parameter int         WDOG_FRAMES = 8,
   parameter int         WDOG_PULSE  = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vbl,
   input  logic       mcu_trig,
   input  logic       vbl_int_clr_cs,
   input  logic       cpu_int_clr_cs,
   input  logic       watchdog_clr_cs,
   input  logic [2:0] m68k_fc,
   input  logic       m68k_as_n,
   output logic [2:0] m68k_ipl_n,
   output logic       m68k_vpa_n,
   output logic       vbl_pend,
   output logic       mcu_pend,
   output logic       wdog_reset
);

   // Index 0 = vblank, index 1 = microcontroller.
   logic [1:0] src;
   logic [1:0] clr_cs;
   logic [1:0] src_prev_reg;
   logic [1:0] clr_prev_reg;
   logic [1:0] src_edge;
   logic [1:0] clr_edge;
   logic [1:0] pend_reg;
   logic [1:0] pend_next;
   logic       armed_reg;
   logic       wdog_active;
   logic [2:0] ipl_n_reg;
   logic       vpa_n_reg;
   logic [2:0] lvl_vbl;
   logic [2:0] lvl_mcu;
   logic [2:0] lvl_max;

   assign src    = {mcu_trig, vbl};
   assign clr_cs = {cpu_int_clr_cs, vbl_int_clr_cs};

   // armed_reg masks the first cycle after reset so a level already high is not an edge.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         assign src_edge[gi]  = armed_reg & src[gi] & ~src_prev_reg[gi];
         assign clr_edge[gi]  = armed_reg & clr_cs[gi] & ~clr_prev_reg[gi];
         assign pend_next[gi] = wdog_active  ? 1'b0 :
                                src_edge[gi] ? 1'b1 :
                                clr_edge[gi] ? 1'b0 : pend_reg[gi];
      end
   endgenerate

   assign lvl_vbl = pend_reg[0] ? VBL_IPL : 3'd0;
   assign lvl_mcu = pend_reg[1] ? MCU_IPL : 3'd0;
   assign lvl_max = (lvl_vbl > lvl_mcu) ? lvl_vbl : lvl_mcu;

   always_ff @(posedge clk) begin
      if (reset) begin
         armed_reg    <= 1'b0;
         src_prev_reg <= 2'b00;
         clr_prev_reg <= 2'b00;
         pend_reg     <= 2'b00;
         ipl_n_reg    <= 3'b111;
         vpa_n_reg    <= 1'b1;
      end else begin
         armed_reg    <= 1'b1;
         src_prev_reg <= src;
         clr_prev_reg <= clr_cs;
         pend_reg     <= pend_next;
         ipl_n_reg    <= ~lvl_max;
         vpa_n_reg    <= ~((m68k_fc == 3'b111) && !m68k_as_n);
      end
   end

   assign m68k_ipl_n = ipl_n_reg;
   assign m68k_vpa_n = vpa_n_reg;
   assign vbl_pend   = pend_reg[0];
   assign mcu_pend   = pend_reg[1];

`ifdef WATCHDOG_EN
   localparam int            CW        = $clog2(WDOG_FRAMES + 1);
   localparam int            PW        = $clog2(WDOG_PULSE + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(WDOG_FRAMES - 1);
   localparam logic [PW-1:0] PULS_LAST = PW'(WDOG_PULSE - 1);

   typedef enum logic {S_RUN, S_FIRE} wdog_state_t;

   wdog_state_t   state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [PW-1:0] pulse_reg, pulse_next;
   logic          wclr_prev_reg;
   logic          wclr_edge;

   assign wclr_edge = armed_reg & watchdog_clr_cs & ~wclr_prev_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= S_RUN;
         cnt_reg       <= '0;
         pulse_reg     <= '0;
         wclr_prev_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         pulse_reg     <= pulse_next;
         wclr_prev_reg <= watchdog_clr_cs;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pulse_next = pulse_reg;
      case (state_reg)
         S_RUN: begin
            // A restart beats a coincident vblank edge.
            if (wclr_edge) begin
               cnt_next = '0;
            end else if (src_edge[0]) begin
               if (cnt_reg == CNT_LAST) begin
                  state_next = S_FIRE;
                  cnt_next   = '0;
                  pulse_next = '0;
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end
         end
         S_FIRE: begin
            if (pulse_reg == PULS_LAST) begin
               state_next = S_RUN;
               cnt_next   = '0;
               pulse_next = '0;
            end else begin
               pulse_next = pulse_reg + PW'(1);
            end
         end
         default: begin
            state_next = S_RUN;
            cnt_next   = '0;
            pulse_next = '0;
         end
      endcase
   end

   assign wdog_active = (state_reg == S_FIRE);
   assign wdog_reset  = wdog_active;
`else
   logic unused_wdog_clr;

   assign unused_wdog_clr = watchdog_clr_cs;
   assign wdog_active     = 1'b0;
   assign wdog_reset      = 1'b0;
`endif

endmodule

// File: tb/tb_m68k_irq_ctrl.sv
// Directed bench for m68k_irq_ctrl: pend latency, priority, clear edges, IACK, watchdog.
module tb_m68k_irq_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       vbl;
   logic       mcu_trig;
   logic       vbl_int_clr_cs;
   logic       cpu_int_clr_cs;
   logic       watchdog_clr_cs;
   logic [2:0] m68k_fc;
   logic       m68k_as_n;
   logic [2:0] m68k_ipl_n;
   logic       m68k_vpa_n;
   logic       vbl_pend;
   logic       mcu_pend;
   logic       wdog_reset;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   m68k_irq_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .vbl             (vbl),
      .mcu_trig        (mcu_trig),
      .vbl_int_clr_cs  (vbl_int_clr_cs),
      .cpu_int_clr_cs  (cpu_int_clr_cs),
      .watchdog_clr_cs (watchdog_clr_cs),
      .m68k_fc         (m68k_fc),
      .m68k_as_n       (m68k_as_n),
      .m68k_ipl_n      (m68k_ipl_n),
      .m68k_vpa_n      (m68k_vpa_n),
      .vbl_pend        (vbl_pend),
      .mcu_pend        (mcu_pend),
      .wdog_reset      (wdog_reset)
   );

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check1(input string tag, input logic observed, input logic expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   task automatic check3(input string tag, input logic [2:0] observed, input logic [2:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   initial begin
      reset           = 1'b1;
      vbl             = 1'b1;
      mcu_trig        = 1'b0;
      vbl_int_clr_cs  = 1'b0;
      cpu_int_clr_cs  = 1'b0;
      watchdog_clr_cs = 1'b0;
      m68k_fc         = 3'b111;
      m68k_as_n       = 1'b0;
      step(3);
      check3("rst_ipl", m68k_ipl_n, 3'b111);
      check1("rst_vpa", m68k_vpa_n, 1'b1);
      check1("rst_vbl_pend", vbl_pend, 1'b0);
      check1("rst_mcu_pend", mcu_pend, 1'b0);
      check1("rst_wdog", wdog_reset, 1'b0);

      // vbl held high through reset release must not register as an edge
      m68k_as_n = 1'b1;
      m68k_fc   = 3'b000;
      reset     = 1'b0;
      step(3);
      check1("no_edge_at_release", vbl_pend, 1'b0);
      check3("no_edge_ipl", m68k_ipl_n, 3'b111);
      vbl = 1'b0;
      step(2);

      // test 1: latency and a long clear strobe
      vbl = 1'b1;
      step();
      check1("t1_pend_n1", vbl_pend, 1'b1);
      check3("t1_ipl_n1", m68k_ipl_n, 3'b111);
      step();
      check3("t1_ipl_n2", m68k_ipl_n, 3'b110);
      vbl = 1'b0;
      vbl_int_clr_cs = 1'b1;
      step();
      check1("t1_clr_pend", vbl_pend, 1'b0);
      step();
      check3("t1_clr_ipl", m68k_ipl_n, 3'b111);
      vbl = 1'b1;
      step();
      check1("t1_set_in_long_clr", vbl_pend, 1'b1);
      step();
      check1("t1_single_clear", vbl_pend, 1'b1);
      vbl_int_clr_cs = 1'b0;
      vbl = 1'b0;
      step();
      vbl_int_clr_cs = 1'b1;
      step();
      check1("t1_reclr_pend", vbl_pend, 1'b0);
      vbl_int_clr_cs = 1'b0;
      step();
      check3("t1_reclr_ipl", m68k_ipl_n, 3'b111);

      // test 2: simultaneous sources, priority
      vbl      = 1'b1;
      mcu_trig = 1'b1;
      step();
      check1("t2_vbl_pend", vbl_pend, 1'b1);
      check1("t2_mcu_pend", mcu_pend, 1'b1);
      step();
      check3("t2_ipl_both", m68k_ipl_n, 3'b101);
      cpu_int_clr_cs = 1'b1;
      step();
      check1("t2_mcu_clr", mcu_pend, 1'b0);
      cpu_int_clr_cs = 1'b0;
      step();
      check3("t2_ipl_vbl_only", m68k_ipl_n, 3'b110);
      vbl_int_clr_cs = 1'b1;
      step();
      vbl_int_clr_cs = 1'b0;
      step();
      check3("t2_ipl_none", m68k_ipl_n, 3'b111);
      vbl      = 1'b0;
      mcu_trig = 1'b0;
      step();

      // test 3: set and clear in the same cycle, set wins
      mcu_trig       = 1'b1;
      cpu_int_clr_cs = 1'b1;
      step();
      check1("t3_set_wins", mcu_pend, 1'b1);
      step();
      check1("t3_hold", mcu_pend, 1'b1);
      check3("t3_ipl", m68k_ipl_n, 3'b101);
      cpu_int_clr_cs = 1'b0;
      mcu_trig       = 1'b0;
      step();
      cpu_int_clr_cs = 1'b1;
      step();
      check1("t3_later_clr", mcu_pend, 1'b0);
      cpu_int_clr_cs = 1'b0;
      step();
      check3("t3_ipl_none", m68k_ipl_n, 3'b111);

      // test 4: IACK autovector
      vbl = 1'b1;
      step();
      vbl = 1'b0;
      step();
      m68k_fc   = 3'b101;
      m68k_as_n = 1'b0;
      step();
      check1("t4_non_iack_vpa", m68k_vpa_n, 1'b1);
      m68k_as_n = 1'b1;
      step();
      m68k_fc   = 3'b111;
      m68k_as_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         check1("t4_vpa_low", m68k_vpa_n, 1'b0);
      end
      m68k_as_n = 1'b1;
      step();
      check1("t4_vpa_release", m68k_vpa_n, 1'b1);
      check1("t4_pend_kept", vbl_pend, 1'b1);
      m68k_fc = 3'b000;
      vbl_int_clr_cs = 1'b1;
      step();
      vbl_int_clr_cs = 1'b0;
      step();

`ifdef WATCHDOG_EN
      // test 5: watchdog expiry, then a restart that defers it
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(2);
      for (int e = 1; e <= 7; e++) begin
         vbl = 1'b1;
         step();
         check1("t5_no_fire", wdog_reset, 1'b0);
         vbl = 1'b0;
         step();
      end
      vbl = 1'b1;
      step();
      for (int i = 0; i < 16; i++) begin
         check1("t5_pulse_high", wdog_reset, 1'b1);
         vbl = (i % 2 == 1);
         step();
      end
      check1("t5_pulse_end", wdog_reset, 1'b0);
      check1("t5_vbl_pend_clr", vbl_pend, 1'b0);
      check1("t5_mcu_pend_clr", mcu_pend, 1'b0);
      vbl = 1'b0;
      step();
      for (int e = 1; e <= 7; e++) begin
         vbl = 1'b1;
         step();
         check1("t5b_no_fire", wdog_reset, 1'b0);
         vbl = 1'b0;
         step();
      end
      watchdog_clr_cs = 1'b1;
      step();
      watchdog_clr_cs = 1'b0;
      step();
      for (int e = 8; e <= 14; e++) begin
         vbl = 1'b1;
         step();
         check1("t5b_restarted", wdog_reset, 1'b0);
         vbl = 1'b0;
         step();
      end
      vbl = 1'b1;
      step();
      check1("t5b_fire_15th", wdog_reset, 1'b1);
      vbl = 1'b0;
      step(16);
      check1("t5b_pulse_end", wdog_reset, 1'b0);
`else
      // test 6: no watchdog in this build
      for (int e = 0; e < 100; e++) begin
         vbl = 1'b1;
         step();
         check1("t6_no_wdog", wdog_reset, 1'b0);
         vbl = 1'b0;
         step();
      end
      check1("t6_pend_kept", vbl_pend, 1'b1);
`endif

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
